aux_mem_arbiter: RTL



---
 rtl/aux_mem_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/aux_mem_arbiter.sv
// aux_mem_arbiter: round-robin arbiter that shares the single auxiliary memory
// port between NUM_REQ requesters. An owner holds the port for a whole burst
// and its read responses come back on the shared rsp_rdata bus.
// Optional feature macro: AUX_ARB_TIMEOUT_EN (idle-owner watchdog with a
// sticky timeout_err flag). Without it the lock is released only by req_last.
module aux_mem_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 32,
   parameter int KEEP_W  = DATA_W / 8,
   parameter int TIMEOUT = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   input  logic [NUM_REQ*KEEP_W-1:0]   req_keep,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          rsp_valid,
   output logic [DATA_W-1:0]           rsp_rdata,
   output logic [KEEP_W-1:0]           aux_mem_keep,
   output logic [DATA_W-1:0]           aux_mem_datai,
   output logic [DATA_W-1:0]           aux_mem_addr,
   output logic                        aux_mem_en,
   input  logic [DATA_W-1:0]           aux_mem_datao,
   output logic                        busy,
   output logic [2:0]                  owner,
   output logic                        timeout_err
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_cfg_check
      $error("aux_mem_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
   end

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t               state;
   logic [2:0]           owner_q;
   logic [NUM_REQ-1:0]   vld_p1;
   logic [NUM_REQ-1:0]   own_oh;
   logic                 sel_valid;
   logic                 sel_last;
   logic [DATA_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic [KEEP_W-1:0]    sel_keep;
   logic                 accept;
   logic                 rd_accept;
   logic [2:0]           rr_next;
   int                   rr_best;
   int                   rr_dist;

`ifdef AUX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     tmo_cnt;
   logic                 tmo_err;
   assign timeout_err = tmo_err;
`else
   assign timeout_err = 1'b0;
`endif

   // Mux the current owner's request slice onto the internal select bus
   always_comb begin
      own_oh    = '0;
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_keep  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == 3'(i)) begin
            own_oh[i] = 1'b1;
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_addr  = req_addr[i*DATA_W +: DATA_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_keep  = req_keep[i*KEEP_W +: KEEP_W];
         end
      end
   end

   // Round-robin pick: nearest requesting index after the last owner, with wrap
   always_comb begin
      rr_next = owner_q;
      rr_best = NUM_REQ;
      rr_dist = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_dist = (i + NUM_REQ - 1 - int'(owner_q)) % NUM_REQ;
         if (req_valid[i] && (rr_dist < rr_best)) begin
            rr_best = rr_dist;
            rr_next = 3'(i);
         end
      end
   end

   // Beat acceptance and memory port drive; the port reads all-zero when idle
   always_comb begin
      accept        = (state == GRANT) && sel_valid;
      rd_accept     = accept && (sel_keep == '0);
      req_ready     = accept ? own_oh : '0;
      aux_mem_en    = accept;
      aux_mem_addr  = accept ? sel_addr  : '0;
      aux_mem_datai = accept ? sel_wdata : '0;
      aux_mem_keep  = accept ? sel_keep  : '0;
   end

   // Arbitration FSM, owner pointer, read-response valid and optional watchdog
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner_q <= 3'(NUM_REQ - 1);
         vld_p1  <= '0;
`ifdef AUX_ARB_TIMEOUT_EN
         tmo_cnt <= '0;
         tmo_err <= 1'b0;
`endif
      end else begin
         vld_p1 <= rd_accept ? own_oh : '0;
         case (state)
            IDLE: begin
`ifdef AUX_ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               if (|req_valid) begin
                  owner_q <= rr_next;
                  state   <= GRANT;
               end
            end
            GRANT: begin
               if (accept && sel_last) begin
                  state <= IDLE;
               end
`ifdef AUX_ARB_TIMEOUT_EN
               if (accept) begin
                  tmo_cnt <= '0;
               end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                  state   <= IDLE;
                  tmo_err <= 1'b1;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The RAM's own output register holds the read word; it is gated onto the
   // shared bus only in the cycle the registered response valid is up.
   assign rsp_valid = vld_p1;
   assign rsp_rdata = (|vld_p1) ? aux_mem_datao : '0;
   assign busy      = (state == GRANT);
   assign owner     = owner_q;

endmodule
